// File: rtl/product_bcd_display.sv
// Captures the multiplier product on each rising edge of Halt and converts it to sign-magnitude BCD.
// Define PRODUCT_SEG7_EN to add registered active-low 7-segment outputs Seg3..Seg0.
module product_bcd_display #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Product,
    input  logic             Halt,
    output logic             Sign,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones,
    output logic             Valid,
`ifdef PRODUCT_SEG7_EN
    output logic [6:0]       Seg3,
    output logic [6:0]       Seg2,
    output logic [6:0]       Seg1,
    output logic [6:0]       Seg0,
`endif
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t             state;
    logic               halt_q;
    logic               sign_r;
    logic [2:0]         cnt;
    logic [WIDTH+11:0]  sr;
    logic [WIDTH+11:0]  adj;
    logic [WIDTH-1:0]   mag;
    logic               trigger;

    assign trigger = Halt & ~halt_q;
    assign mag     = Product[WIDTH-1] ? (~Product + {{(WIDTH-1){1'b0}}, 1'b1}) : Product;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

`ifdef PRODUCT_SEG7_EN
    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction
`endif

    always_comb begin
        adj = sr;
        adj[WIDTH+11:WIDTH+8] = add3(sr[WIDTH+11:WIDTH+8]);
        adj[WIDTH+7:WIDTH+4]  = add3(sr[WIDTH+7:WIDTH+4]);
        adj[WIDTH+3:WIDTH]    = add3(sr[WIDTH+3:WIDTH]);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            halt_q   <= 1'b0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            sr       <= '0;
            Sign     <= 1'b0;
            Hundreds <= '0;
            Tens     <= '0;
            Ones     <= '0;
            Valid    <= 1'b0;
            Busy     <= 1'b0;
`ifdef PRODUCT_SEG7_EN
            Seg3     <= 7'h7F;
            Seg2     <= 7'h7F;
            Seg1     <= 7'h7F;
            Seg0     <= 7'h7F;
`endif
        end else begin
            // Halt_q tracks Halt in every state, so edges seen mid-conversion are dropped
            halt_q <= Halt;
            Valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        sign_r <= Product[WIDTH-1] & (mag != '0);
                        sr     <= {12'd0, mag};
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr  <= {adj[WIDTH+10:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    Hundreds <= sr[WIDTH+11:WIDTH+8];
                    Tens     <= sr[WIDTH+7:WIDTH+4];
                    Ones     <= sr[WIDTH+3:WIDTH];
                    Sign     <= sign_r;
`ifdef PRODUCT_SEG7_EN
                    Seg3     <= sign_r ? 7'b0111111 : 7'h7F;
                    Seg2     <= (sr[WIDTH+11:WIDTH+8] == 4'd0) ? 7'h7F : seg7(sr[WIDTH+11:WIDTH+8]);
                    Seg1     <= (sr[WIDTH+11:WIDTH+4] == 8'd0) ? 7'h7F : seg7(sr[WIDTH+7:WIDTH+4]);
                    Seg0     <= seg7(sr[WIDTH+3:WIDTH]);
`endif
                    Valid    <= 1'b1;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display: vector table plus hold/retrigger/reset sequences.
module tb_product_bcd_display;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Product;
    logic       Halt;
    logic       Sign;
    logic [3:0] Hundreds, Tens, Ones;
    logic       Valid, Busy;
`ifdef PRODUCT_SEG7_EN
    logic [6:0] Seg3, Seg2, Seg1, Seg0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    product_bcd_display #(.WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .Product(Product), .Halt(Halt),
        .Sign(Sign), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
        .Valid(Valid),
`ifdef PRODUCT_SEG7_EN
        .Seg3(Seg3), .Seg2(Seg2), .Seg1(Seg1), .Seg0(Seg0),
`endif
        .Busy(Busy)
    );

    typedef struct {
        logic [7:0] prod;
        logic       sign;
        logic [3:0] h, t, o;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

`ifdef PRODUCT_SEG7_EN
    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction
`endif

    // Raise Halt with product p; lat = negedge index of first Valid (10 means 9 clocks after E0)
    task automatic run_conv(input logic [7:0] p, output int lat, output int busy_cycles);
        @(negedge Clock);
        Product = p;
        Halt    = 1'b1;
        lat = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (Busy) busy_cycles++;
            if (Valid) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t vecs [9];
    int   lat, bc, pulses;

    initial begin
        vecs[0] = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[1] = '{8'h40, 1'b0, 4'd0, 4'd6, 4'd4};
        vecs[2] = '{8'hC8, 1'b1, 4'd0, 4'd5, 4'd6};
        vecs[3] = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
        vecs[4] = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
        vecs[5] = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
        vecs[6] = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
        vecs[7] = '{8'h0A, 1'b0, 4'd0, 4'd1, 4'd0};
        vecs[8] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};

        Reset = 1'b1; Product = 8'h00; Halt = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_sign", Sign, 0);
        check("rst_digits", {Hundreds, Tens, Ones}, 0);
        check("rst_valid", Valid, 0);
        check("rst_busy", Busy, 0);
`ifdef PRODUCT_SEG7_EN
        check("rst_seg", {Seg3, Seg2, Seg1, Seg0}, {4{7'h7F}});
`endif
        Reset = 1'b0;
        @(negedge Clock);

        for (int v = 0; v < 9; v++) begin
            run_conv(vecs[v].prod, lat, bc);
            check($sformatf("latency[%0d]", v), lat, 10);
            check($sformatf("busy_cycles[%0d]", v), bc, 9);
            check($sformatf("sign[%0d]", v), Sign, vecs[v].sign);
            check($sformatf("hundreds[%0d]", v), Hundreds, vecs[v].h);
            check($sformatf("tens[%0d]", v), Tens, vecs[v].t);
            check($sformatf("ones[%0d]", v), Ones, vecs[v].o);
`ifdef PRODUCT_SEG7_EN
            check($sformatf("seg3[%0d]", v), Seg3, vecs[v].sign ? 7'b0111111 : 7'h7F);
            check($sformatf("seg2[%0d]", v), Seg2, (vecs[v].h == 0) ? 7'h7F : exp_seg(vecs[v].h));
            check($sformatf("seg1[%0d]", v), Seg1,
                  (vecs[v].h == 0 && vecs[v].t == 0) ? 7'h7F : exp_seg(vecs[v].t));
            check($sformatf("seg0[%0d]", v), Seg0, exp_seg(vecs[v].o));
`endif
            Halt = 1'b0;
            @(negedge Clock);
            check($sformatf("valid_pulse[%0d]", v), Valid, 0);
            check($sformatf("hold[%0d]", v), {Sign, Hundreds, Tens, Ones},
                  {vecs[v].sign, vecs[v].h, vecs[v].t, vecs[v].o});
            @(negedge Clock);
        end

        // Halt held high 50 clocks: one conversion only
        @(negedge Clock);
        Product = 8'h40; Halt = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (Valid) pulses++;
        end
        check("hold_high_pulses", pulses, 1);
        check("hold_high_ones", Ones, 4);
        Halt = 1'b0;
        repeat (2) @(negedge Clock);

        // Second Halt rise sampled at E4 is dropped
        Product = 8'h0A; Halt = 1'b1;
        pulses = 0;
        repeat (3) @(negedge Clock);     // after E2
        Halt = 1'b0;
        @(negedge Clock);                // after E3
        Product = 8'h7F; Halt = 1'b1;    // E4 sees a rising edge
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (Valid) pulses++;
        end
        check("retrigger_pulses", pulses, 1);
        check("retrigger_digits", {Hundreds, Tens, Ones}, 12'h010);
        Halt = 1'b0;
        repeat (2) @(negedge Clock);

        // Reset at E5 of a 0xC8 conversion, Halt kept high through reset
        Product = 8'hC8; Halt = 1'b1;
        pulses = 0;
        repeat (5) @(negedge Clock);     // after E4
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            if (Valid) pulses++;
        end
        check("midrst_valid", pulses, 0);
        check("midrst_outputs", {Sign, Hundreds, Tens, Ones}, 0);
        check("midrst_busy", Busy, 0);
`ifdef PRODUCT_SEG7_EN
        check("midrst_seg", {Seg3, Seg2, Seg1, Seg0}, {4{7'h7F}});
`endif
        Reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (Valid) begin
                lat = i;
                break;
            end
        end
        check("postrst_latency", lat, 10);
        check("postrst_result", {Sign, Hundreds, Tens, Ones}, {1'b1, 12'h056});
        Halt = 1'b0;
        repeat (2) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_bcd_display.md
# product_bcd_display

Downstream consumer of the 4x4 signed multiplier. It watches the multiplier's `Halt` output and, on each completed multiplication, captures the 8-bit two's-complement `Product`. It converts the product to sign-magnitude BCD (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine, one iteration per clock. It then holds the result for the board display logic.

## Interface
- `WIDTH`, default 8: product width; fixed at 8 for this design. Magnitude range is 0..128.
- `Clock`, input, 1: system clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Product`, input, 8: two's-complement product from the multiplier; sampled only at the trigger edge.
- `Halt`, input, 1: multiplier done level. It stays high while the multiplier is halted.
- `Sign`, output, 1: 1 = negative result.
- `Hundreds`, output, 4: BCD hundreds digit (0 or 1).
- `Tens`, output, 4: BCD tens digit.
- `Ones`, output, 4: BCD ones digit.
- `Valid`, output, 1: one-cycle pulse when the BCD outputs update.
- `Busy`, output, 1: high while a conversion is in progress.

## Operation
- `Halt_q` register holds the previous `Halt` value. Trigger = `Halt & ~Halt_q`, so each multiplication is detected on the rising edge of `Halt` only.
- States:
  - IDLE -> CONVERT on trigger.
  - CONVERT -> DONE after 8 iterations.
  - DONE -> IDLE unconditionally.
- IDLE with trigger:
  - `sign_r` <= `Product[7]`.
  - Magnitude = `Product[7]` ? (~`Product` + 1) : `Product`, as a 8-bit unsigned value. 0x80 gives 128.
  - Shift register {bcd[11:0], bin[7:0]} <= {12'd0, magnitude}.
  - Iteration counter `cnt` <= 0.
- CONVERT, each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift the whole 20-bit register left by 1.
  - `cnt` <= `cnt` + 1.
  - When `cnt` == 7, go to DONE.
- DONE:
  - Load `Hundreds`/`Tens`/`Ones` from bcd[11:8]/[7:4]/[3:0].
  - `Sign` <= `sign_r` & (magnitude != 0).
  - Pulse `Valid`, then return to IDLE.
- Output registers change only in DONE. Between conversions they hold the last result.
- Trigger while in CONVERT or DONE is ignored. `Halt_q` still tracks `Halt`, so a rising edge that occurs during a conversion is lost and is not replayed.
- `Halt` held high indefinitely produces exactly one conversion.
- Reset mid-conversion:
  - All state returns to IDLE, all outputs are cleared, and no `Valid` is issued.
  - `Halt_q` clears to 0. If `Halt` is high when `Reset` drops, the next clock is treated as a trigger.

## Timing
- Reset values: `Sign`=0, `Hundreds`=`Tens`=`Ones`=0, `Valid`=0, `Busy`=0, state IDLE, `Halt_q`=0, `cnt`=0.
- Edge E0 is the clock edge at which `Halt`=1 and `Halt_q`=0 are sampled in IDLE.
- `Busy` is high from E0 through E9 (9 cycles).
- E1..E8 are the 8 double-dabble iterations.
- E9 (DONE) updates the outputs and raises `Valid` for exactly one cycle.
- Latency: `Valid` and the new digits are visible 9 clocks after E0.
- Minimum trigger-to-trigger spacing for a new capture: 10 clocks. The multiplier's own latency exceeds this.

## Configuration
- `PRODUCT_SEG7_EN` defined adds four active-low 7-segment outputs. Each is 7 bits in order {g,f,e,d,c,b,a}.
  - `Seg3` shows the sign: minus (7'b0111111) if `Sign`, else blank (7'h7F).
  - `Seg2` shows hundreds, blank when hundreds is 0.
  - `Seg1` shows tens, blank when hundreds and tens are both 0.
  - `Seg0` always shows ones.
  - All four are registered, update in DONE together with the BCD outputs, and reset to 7'h7F.
- `PRODUCT_SEG7_EN` undefined: the `Seg*` ports and their logic are absent. BCD behaviour is unchanged.

## Test plan
- Reset, then `Product`=0x00 with a `Halt` rise -> after 9 clocks `Valid`=1, `Sign`=0, digits 0/0/0.
- `Product`=0x40 (-8 x -8 = +64) -> `Sign`=0, 0/6/4. With `PRODUCT_SEG7_EN`, `Seg2` blank and `Seg1`/`Seg0` show 6/4.
- `Product`=0xC8 (-56) -> `Sign`=1, 0/5/6. With `PRODUCT_SEG7_EN`, `Seg3` shows minus.
- `Product`=0x80 -> `Sign`=1, 1/2/8. `Product`=0x7F -> `Sign`=0, 1/2/7.
- `Halt` held high for 50 clocks -> exactly one `Valid` pulse. A second `Halt` rise at E4 -> ignored, no second `Valid`.
- `Reset` asserted at E5 of a conversion of 0xC8 -> all outputs 0, no `Valid`. After `Reset` deasserts with `Halt` still high -> a new conversion starts on the next edge.
